// File: rtl/dma_pkg.sv
// DMA datapath shared types: write-burst descriptor, strobe geometry and write-streamer states.
package dma_pkg;

  localparam int DMA_DATA_W = 512;
  localparam int DMA_STRB_W = DMA_DATA_W / 8;
  localparam int DMA_HEAD_W = 6;
  localparam int DMA_TAIL_W = 6;
  localparam int DMA_LEN_W  = 8;

  typedef struct packed {
    logic [DMA_HEAD_W-1:0] head;
    logic [DMA_TAIL_W-1:0] tail;
    logic [DMA_LEN_W-1:0]  alen;
  } s_dma_wburst_req_t;

  typedef enum logic [0:0] {
    DMA_WS_IDLE   = 1'b0,
    DMA_WS_STREAM = 1'b1
  } e_dma_wstream_state_t;

  // A single-beat burst whose first valid byte lies after its last one carries no data.
  function automatic logic dma_wburst_illegal(input s_dma_wburst_req_t d);
    return (d.alen == {DMA_LEN_W{1'b0}}) && (d.head > d.tail);
  endfunction

endpackage

// File: rtl/venus_soc_pkg.sv
// SoC-wide AXI type definitions shared by the DMA datapath blocks.
package venus_soc_pkg;

  localparam int AXI_DATA_W = 512;

  typedef logic [AXI_DATA_W-1:0] axi_data_t;

endpackage

// File: rtl/dma_wstrb_gen.sv
// Per-beat AXI byte-strobe generator from head/tail offsets and first/last beat flags.
import dma_pkg::*;

module dma_wstrb_gen #(
  parameter int STRB_W = DMA_STRB_W
) (
  input  logic [DMA_HEAD_W-1:0] head,
  input  logic [DMA_TAIL_W-1:0] tail,
  input  logic                  first,
  input  logic                  last,
  output logic [STRB_W-1:0]     wstrb
);

  localparam logic [DMA_TAIL_W-1:0] TAIL_MAX = DMA_TAIL_W'(STRB_W - 1);

  function automatic logic [STRB_W-1:0] mask_hi(input logic [DMA_HEAD_W-1:0] h);
    return {STRB_W{1'b1}} << h;
  endfunction

  function automatic logic [STRB_W-1:0] mask_lo(input logic [DMA_TAIL_W-1:0] t);
    return {STRB_W{1'b1}} >> (TAIL_MAX - t);
  endfunction

  // Select the strobe shape by beat position; a head>tail single beat collapses to zero.
  always_comb begin
    wstrb = {STRB_W{1'b1}};
    case ({first, last})
      2'b11:   wstrb = mask_hi(head) & mask_lo(tail);
      2'b10:   wstrb = mask_hi(head);
      2'b01:   wstrb = mask_lo(tail);
      default: wstrb = {STRB_W{1'b1}};
    endcase
  end

endmodule

// File: rtl/dma_wdata_streamer.sv
// AXI W-channel streamer: pops destination-aligned beats from the aligner FIFO, one burst per descriptor.
// Optional build macro DMA_WSTREAM_ERR_EN adds the sticky err_o port and descriptor/underflow checking.
import dma_pkg::*;
import venus_soc_pkg::*;

module dma_wdata_streamer #(
  parameter  int DATA_W = 512,
  parameter  int LEN_W  = DMA_LEN_W,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  s_dma_wburst_req_t req_i,
  input  logic              fifo_empty_i,
  input  axi_data_t         fifo_data_i,
  output logic              fifo_rd_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic              wlast_o,
  output logic              done_o
`ifdef DMA_WSTREAM_ERR_EN
  ,
  output logic              err_o
`endif
);

  localparam logic [0:0]     ST_IDLE   = DMA_WS_IDLE;
  localparam logic [0:0]     ST_STREAM = DMA_WS_STREAM;
  localparam logic [LEN_W:0] BEAT_ZERO = {(LEN_W+1){1'b0}};
  localparam logic [LEN_W:0] BEAT_ONE  = {{LEN_W{1'b0}}, 1'b1};

  logic [0:0]            state_r;
  logic [DMA_HEAD_W-1:0] head_r;
  logic [DMA_TAIL_W-1:0] tail_r;
  logic [LEN_W:0]        beats_left_r;
  logic                  first_r;
  logic                  wvalid_r;
  logic                  wlast_r;
  logic                  done_r;
  logic [DATA_W-1:0]     wdata_r;
  logic [STRB_W-1:0]     wstrb_r;

  logic                  accept_s;
  logic                  load_s;
  logic                  hs_s;
  logic                  last_beat_s;
  logic [STRB_W-1:0]     wstrb_s;

  assign accept_s    = (state_r == ST_IDLE) & req_valid_i;
  assign last_beat_s = (beats_left_r == BEAT_ONE);
  assign hs_s        = wvalid_r & wready_i;
  // A new beat enters the output register only when it is empty or being drained this cycle.
  assign load_s      = (state_r == ST_STREAM) & ~fifo_empty_i & (beats_left_r != BEAT_ZERO)
                     & (~wvalid_r | wready_i);

  dma_wstrb_gen #(
    .STRB_W (STRB_W)
  ) u_wstrb_gen (
    .head  (head_r),
    .tail  (tail_r),
    .first (first_r),
    .last  (last_beat_s),
    .wstrb (wstrb_s)
  );

  // Burst control: descriptor latch, beat countdown and IDLE/STREAM sequencing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      head_r       <= {DMA_HEAD_W{1'b0}};
      tail_r       <= {DMA_TAIL_W{1'b0}};
      beats_left_r <= BEAT_ZERO;
      first_r      <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= hs_s & wlast_r;
      case (state_r)
        ST_IDLE: begin
          if (req_valid_i) begin
            head_r       <= req_i.head;
            tail_r       <= req_i.tail;
            beats_left_r <= (LEN_W+1)'(req_i.alen) + BEAT_ONE;
            first_r      <= 1'b1;
            state_r      <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (load_s) begin
            beats_left_r <= beats_left_r - BEAT_ONE;
            first_r      <= 1'b0;
          end
          if (hs_s & wlast_r) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // W output register: payload is frozen while wvalid is high and wready is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wvalid_r <= 1'b0;
      wlast_r  <= 1'b0;
      wdata_r  <= {DATA_W{1'b0}};
      wstrb_r  <= {STRB_W{1'b0}};
    end else if (load_s) begin
      wvalid_r <= 1'b1;
      wlast_r  <= last_beat_s;
      wdata_r  <= DATA_W'(fifo_data_i);
      wstrb_r  <= wstrb_s;
    end else if (hs_s) begin
      wvalid_r <= 1'b0;
    end
  end

`ifdef DMA_WSTREAM_ERR_EN
  logic err_r;

  // Sticky error on an illegal descriptor or a pop against an empty FIFO; only reset clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_r <= 1'b0;
    end else if ((accept_s & dma_wburst_illegal(req_i)) | (load_s & fifo_empty_i)) begin
      err_r <= 1'b1;
    end
  end

  assign err_o = err_r;
`else
  logic unused_accept_s;
  assign unused_accept_s = accept_s;
`endif

  assign req_ready_o = (state_r == ST_IDLE);
  assign fifo_rd_o   = load_s;
  assign wvalid_o    = wvalid_r;
  assign wlast_o     = wlast_r;
  assign wdata_o     = wdata_r;
  assign wstrb_o     = wstrb_r;
  assign done_o      = done_r;

endmodule

// File: tb/tb_dma_wdata_streamer.sv
// Directed self-checking bench for dma_wdata_streamer with a small FIFO model and W-beat monitor.
module tb_dma_wdata_streamer;
  import dma_pkg::*;
  import venus_soc_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  s_dma_wburst_req_t req = '0;
  logic              fifo_empty;
  axi_data_t         fifo_data;
  logic              fifo_rd;
  logic              wvalid;
  logic              wready = 1'b1;
  axi_data_t         wdata;
  logic [63:0]       wstrb;
  logic              wlast;
  logic              done;
`ifdef DMA_WSTREAM_ERR_EN
  logic              err;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dma_wdata_streamer #(.DATA_W(512), .LEN_W(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_i        (req),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_rd_o    (fifo_rd),
    .wvalid_o     (wvalid),
    .wready_i     (wready),
    .wdata_o      (wdata),
    .wstrb_o      (wstrb),
    .wlast_o      (wlast),
    .done_o       (done)
`ifdef DMA_WSTREAM_ERR_EN
    ,
    .err_o        (err)
`endif
  );

  // FIFO model: first-word-fall-through, read side advanced by the DUT's pop.
  axi_data_t mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int next_id = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr[3:0]];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) rd_ptr <= 0;
    else if (fifo_rd) rd_ptr <= rd_ptr + 1;
  end

  // Monitor samples 1 ns before each rising edge; cyc labels that edge.
  axi_data_t   cap_data[$];
  logic [63:0] cap_strb[$];
  logic        cap_last[$];
  int          cap_cyc[$];
  int cyc = 0, done_cnt = 0, done_cyc = -1, pops = 0, stall_pops = 0;

  always @(negedge clk) begin
    #4;
    if (rstn && wvalid && wready) begin
      cap_data.push_back(wdata);
      cap_strb.push_back(wstrb);
      cap_last.push_back(wlast);
      cap_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (fifo_rd) begin
      pops <= pops + 1;
      if (wvalid && !wready) stall_pops <= stall_pops + 1;
    end
    cyc <= cyc + 1;
  end

  function automatic axi_data_t mkword(input int k);
    return {16{32'(k) ^ 32'hC3A5_0000}};
  endfunction

  task automatic push_word();
    mem[wr_ptr[3:0]] = mkword(next_id);
    next_id = next_id + 1;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic send_req(input logic [5:0] h, input logic [5:0] t, input logic [7:0] l, output int acc);
    @(negedge clk);
    req = '{head: h, tail: t, alen: l};
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin acc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++;
    if (acc < 0) begin n_bad++; $display("FAIL accept: req_ready never seen, required within 20 cycles"); end
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > d0) break;
    end
    n_vec++;
    if (done_cnt <= d0) begin n_bad++; $display("FAIL done_timeout: done_o not seen within %0d cycles", budget); end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    wr_ptr = 0;
    #1;
    n_vec++;
    if ({wvalid, wlast, fifo_rd, done, req_ready} !== 5'b00001 || wdata !== '0 || wstrb !== 64'h0) begin
      n_bad++;
      $display("FAIL reset: vld/last/rd/done/rdy=%b%b%b%b%b strb=%h, required 00001 strb=0 data=0",
               wvalid, wlast, fifo_rd, done, req_ready, wstrb);
    end
`ifdef DMA_WSTREAM_ERR_EN
    n_vec++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: err=%b required 0", err); end
`endif
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_multi_beat();
    int a, base, id0, d0;
    logic [63:0] es [4];
    es = '{64'hFFFF_FFFF_FFFF_E000, ONES, ONES, 64'h0000_0000_0000_3FFF};
    base = cap_data.size(); id0 = next_id; d0 = done_cnt;
    wready = 1'b1;
    repeat (4) push_word();
    send_req(6'd13, 6'd13, 8'd3, a);
    wait_done(d0, 40);
    @(negedge clk);
    n_vec++;
    if (cap_data.size() - base !== 4) begin n_bad++; $display("FAIL multi_count: %0d beats, required 4", cap_data.size() - base); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (base + i >= cap_data.size() || cap_strb[base+i] !== es[i] || cap_last[base+i] !== (i == 3)
          || cap_data[base+i] !== mkword(id0 + i)) begin
        n_bad++;
        $display("FAIL multi_beat%0d: wrong strb/last/data, required strb=%h last=%b", i, es[i], (i == 3));
      end
    end
    n_vec++;
    if (cap_data.size() <= base || cap_cyc[base] !== a + 2) begin n_bad++; $display("FAIL multi_first_latency: required beat at edge %0d", a + 2); end
    n_vec++;
    if (done_cyc !== a + 6 || done_cnt - d0 !== 1) begin
      n_bad++; $display("FAIL multi_done: at edge %0d count %0d, required edge %0d count 1", done_cyc, done_cnt - d0, a + 6);
    end
  endtask

  task automatic test_single_beat();
    int a, base, id0, d0;
    base = cap_data.size(); id0 = next_id; d0 = done_cnt;
    push_word();
    send_req(6'd3, 6'd7, 8'd0, a);
    wait_done(d0, 20);
    n_vec++;
    if (cap_data.size() - base !== 1 || cap_strb[base] !== 64'h0000_0000_0000_00F8 || cap_last[base] !== 1'b1
        || cap_data[base] !== mkword(id0)) begin
      n_bad++; $display("FAIL single: beats=%0d, required 1 beat strb=00000000000000f8 last=1", cap_data.size() - base);
    end
    n_vec++;
    if (done_cyc !== a + 3) begin n_bad++; $display("FAIL single_done: edge %0d required %0d", done_cyc, a + 3); end
  endtask

  task automatic test_wready_stall();
    int a, base, id0, d0, p0, sp0, stalls;
    logic [63:0] es [3];
    es = '{64'hFFFF_FFFF_FFFF_FFF0, ONES, 64'h0FFF_FFFF_FFFF_FFFF};
    base = cap_data.size(); id0 = next_id; d0 = done_cnt; p0 = pops; sp0 = stall_pops; stalls = 0;
    repeat (3) push_word();
    send_req(6'd4, 6'd59, 8'd2, a);
    for (int i = 0; i < 60; i++) begin
      if (done_cnt > d0) break;
      if (cap_data.size() - base == 1 && stalls < 3) begin
        wready = 1'b0;
        stalls++;
        n_vec++;
        if (wvalid !== 1'b1 || wdata !== mkword(id0 + 1) || wstrb !== ONES || wlast !== 1'b0) begin
          n_bad++; $display("FAIL stall_hold%0d: vld=%b strb=%h last=%b, required 1 %h 0", stalls, wvalid, wstrb, wlast, ONES);
        end
      end else begin
        wready = 1'b1;
      end
      @(negedge clk);
    end
    wready = 1'b1;
    wait_done(d0, 20);
    n_vec++;
    if (cap_data.size() - base !== 3 || pops - p0 !== 3 || stall_pops - sp0 !== 0 || stalls !== 3) begin
      n_bad++; $display("FAIL stall_counts: beats=%0d pops=%0d stalled_pops=%0d stalls=%0d, required 3 3 0 3",
                        cap_data.size() - base, pops - p0, stall_pops - sp0, stalls);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (base + i >= cap_data.size() || cap_strb[base+i] !== es[i] || cap_last[base+i] !== (i == 2)
          || cap_data[base+i] !== mkword(id0 + i)) begin
        n_bad++; $display("FAIL stall_beat%0d: wrong strb/last/data, required strb=%h", i, es[i]);
      end
    end
  endtask

  task automatic test_fifo_empty();
    int a, base, id0, d0, low_bad;
    base = cap_data.size(); id0 = next_id; d0 = done_cnt; low_bad = 0;
    push_word();
    send_req(6'd10, 6'd20, 8'd1, a);
    for (int i = 0; i < 20; i++) begin
      if (cap_data.size() - base >= 1) break;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      if (wvalid !== 1'b0) low_bad++;
      @(negedge clk);
    end
    n_vec++;
    if (low_bad != 0) begin n_bad++; $display("FAIL empty_gap: wvalid high in %0d of 5 starved cycles, required 0", low_bad); end
    push_word();
    wait_done(d0, 20);
    repeat (3) @(negedge clk);
    n_vec++;
    if (cap_data.size() - base !== 2 || done_cnt - d0 !== 1) begin
      n_bad++; $display("FAIL empty_counts: beats=%0d dones=%0d, required 2 1", cap_data.size() - base, done_cnt - d0);
    end
    n_vec++;
    if (cap_strb[base] !== 64'hFFFF_FFFF_FFFF_FC00 || cap_last[base] !== 1'b0 || cap_strb[base+1] !== 64'h0000_0000_001F_FFFF
        || cap_last[base+1] !== 1'b1 || cap_data[base+1] !== mkword(id0 + 1)) begin
      n_bad++; $display("FAIL empty_beats: strb %h/%h, required fffffffffffffc00/00000000001fffff", cap_strb[base], cap_strb[base+1]);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, base, id0, d0;
    logic [63:0] es [3];
    es = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h3FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FF00};
    base = cap_data.size(); id0 = next_id; d0 = done_cnt;
    repeat (3) push_word();
    @(negedge clk);
    req = '{head: 6'd2, tail: 6'd61, alen: 8'd1};
    req_valid = 1'b1;
    a1 = -1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin a1 = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req = '{head: 6'd8, tail: 6'd15, alen: 8'd0};
    a2 = -1;
    for (int i = 0; i < 30; i++) begin
      if (req_ready) begin a2 = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++;
    if (a1 < 0 || a2 < 0 || a2 !== done_cyc) begin
      n_bad++; $display("FAIL b2b_accept: second accept at edge %0d, required done edge %0d", a2, done_cyc);
    end
    wait_done(d0 + 1, 20);
    n_vec++;
    if (cap_data.size() - base !== 3) begin n_bad++; $display("FAIL b2b_count: %0d beats, required 3", cap_data.size() - base); end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (base + i >= cap_data.size() || cap_strb[base+i] !== es[i] || cap_last[base+i] !== (i != 0)
          || cap_data[base+i] !== mkword(id0 + i)) begin
        n_bad++; $display("FAIL b2b_beat%0d: wrong strb/last/data, required strb=%h last=%b", i, es[i], (i != 0));
      end
    end
  endtask

  task automatic test_illegal_desc();
    int a, base, d0;
    base = cap_data.size(); d0 = done_cnt;
    push_word();
    send_req(6'd9, 6'd2, 8'd0, a);
    wait_done(d0, 20);
    n_vec++;
    if (cap_data.size() - base !== 1 || cap_strb[base] !== 64'h0 || cap_last[base] !== 1'b1) begin
      n_bad++; $display("FAIL illegal: beats=%0d strb=%h, required 1 beat strb=0 last=1", cap_data.size() - base, cap_strb[base]);
    end
`ifdef DMA_WSTREAM_ERR_EN
    repeat (2) @(negedge clk);
    n_vec++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_err: err=%b required 1 (sticky)", err); end
`endif
  endtask

  task automatic test_reset_mid_burst();
    int a, base, id0, d0;
    base = cap_data.size(); d0 = done_cnt;
    repeat (4) push_word();
    send_req(6'd0, 6'd63, 8'd3, a);
    for (int i = 0; i < 20; i++) begin
      if (cap_data.size() - base >= 1) break;
      @(negedge clk);
    end
    #2 rstn = 1'b0;
    wr_ptr = 0;
    #1;
    n_vec++;
    if ({wvalid, wlast, fifo_rd, done, req_ready} !== 5'b00001 || wdata !== '0 || wstrb !== 64'h0) begin
      n_bad++; $display("FAIL midreset: vld/last/rd/done/rdy=%b%b%b%b%b strb=%h, required 00001 strb=0",
                        wvalid, wlast, fifo_rd, done, req_ready, wstrb);
    end
`ifdef DMA_WSTREAM_ERR_EN
    n_vec++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL midreset_err: err=%b required 0", err); end
`endif
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    base = cap_data.size(); id0 = next_id; d0 = done_cnt;
    push_word();
    send_req(6'd0, 6'd0, 8'd0, a);
    wait_done(d0, 20);
    n_vec++;
    if (cap_data.size() - base !== 1 || cap_strb[base] !== 64'h1 || cap_last[base] !== 1'b1
        || cap_data[base] !== mkword(id0)) begin
      n_bad++; $display("FAIL post_reset: beats=%0d strb=%h, required 1 beat strb=1 last=1", cap_data.size() - base, cap_strb[base]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_multi_beat();
    test_single_beat();
    test_wready_stall();
    test_fifo_empty();
    test_back_to_back();
    test_illegal_desc();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_wdata_streamer.md
# dma_wdata_streamer

Write-side transmitter of the DMA datapath: consumes destination-aligned beats from the aligner's output FIFO and drives the AXI W channel (wdata/wstrb/wlast) of one write burst per request. It is the counterpart of `dma_shift_aligner`. The aligner packs read data into destination alignment. This block turns the destination head/tail/alen descriptor into per-beat byte strobes and paces beats against `wready`.

## Interface
Parameters:
- `DATA_W`, 512: W data width in bits; `STRB_W = DATA_W/8` (64).
- `LEN_W`, 8: width of the burst length field (beats-1).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `req_valid_i`  in  1: burst descriptor valid.
- `req_ready_o`  out  1: descriptor accepted when both high.
- `req_i`  in  `s_dma_wburst_req_t`: `head` (first valid byte in first beat, 0..63), `tail` (last valid byte in last beat, 0..63), `alen` (beats-1).
- `fifo_empty_i`  in  1: aligner FIFO empty (first-word-fall-through).
- `fifo_data_i`  in  `axi_data_t`: FIFO head word.
- `fifo_rd_o`  out  1: pop FIFO head this cycle.
- `wvalid_o`  out  1; `wready_i`  in  1: AXI W handshake.
- `wdata_o`  out  `DATA_W`; `wstrb_o`  out  `STRB_W`; `wlast_o`  out  1.
- `done_o`  out  1: one-cycle pulse after the last beat handshake.
- `err_o`  out  1: only with `DMA_WSTREAM_ERR_EN` (see Configuration).

## Operation
- FSM states:
  - IDLE: `req_ready_o`=1. On `req_valid_i`, latch the descriptor, load `beats_left = alen+1` and `first = 1`, then go to STREAM.
  - STREAM: `req_ready_o`=0. Go to IDLE on the handshake `wvalid_o & wready_i & wlast_o`.
- Output register holds `wdata_o`, `wstrb_o`, `wlast_o` and `wvalid_o`.
- Load condition: `load = STREAM & !fifo_empty_i & (beats_left != 0) & (!wvalid_o | wready_i)`.
- `fifo_rd_o = load` (combinational). On `load`:
  - register `fifo_data_i` into the output register;
  - decrement `beats_left`;
  - clear `first`;
  - set `wlast_o = (beats_left == 1)`.
- `wvalid_o`:
  - sets on `load`;
  - clears on a handshake without a simultaneous `load`;
  - holds otherwise.
- While `wvalid_o & !wready_i`, `wdata_o`, `wstrb_o` and `wlast_o` are stable (AXI rule).
- Strobe per beat (bit i = byte i):
  - single beat (alen=0): bits head..tail;
  - first of several: bits head..63;
  - last of several: bits 0..tail;
  - middle: all ones.
- Strobe generation: `mask_hi(head) = ~0 << head`, `mask_lo(tail) = ~0 >> (63-tail)`, ANDed for a single beat. Shifts are done at `STRB_W` width with no truncation.
- FIFO empty mid-burst: no pop. `wvalid_o` drops after the held beat is taken, and the burst resumes when data arrives. No beat duplication or skipping.
- Illegal descriptor (alen=0 and head>tail): strobe is all zero and the beat is still sent with `wlast_o`=1.
- Reset, including mid-burst: all state cleared immediately. The FIFO is reset by its owner in the same domain.

## Timing
- Reset values:
  - `req_ready_o`=1 (IDLE);
  - `wvalid_o`, `wlast_o`, `fifo_rd_o`, `done_o`, `err_o` = 0;
  - `wdata_o`, `wstrb_o` = 0.
- Accept at edge N → STREAM in cycle N+1. With the FIFO non-empty, the pop happens in N+1 and `wvalid_o` is high in N+2.
- Throughput: 1 beat/cycle with `wready_i` high and the FIFO non-empty.
- `done_o` pulses in the cycle after the final handshake. In that same cycle the FSM is in IDLE and `req_ready_o`=1, so a back-to-back descriptor can be accepted there.
- `req_valid_i` during STREAM is ignored (ready low). The requester holds it.

## Configuration
- `DMA_WSTREAM_ERR_EN` defined:
  - port `err_o` exists;
  - `err_o` sets sticky on acceptance of an illegal descriptor (alen=0, head>tail);
  - `err_o` sets sticky on a pop while `fifo_empty_i` (underflow guard);
  - cleared only by reset.
- Not defined: no `err_o` port and no checking logic. Illegal-descriptor behaviour (zero strobe) is unchanged.

## Structure
- Shared package `dma_pkg` holds:
  - `s_dma_wburst_req_t`;
  - `DMA_STRB_W`;
  - head/tail/len field widths;
  - FSM enum `e_dma_wstream_state_t` (IDLE, STREAM).
- `axi_data_t` comes from `venus_soc_pkg`.
- One sub-module: `dma_wstrb_gen`, combinational. Inputs: head, tail, first, last. Output: `wstrb`. It is reusable by the aligner's strobe path.

## Test plan
- alen=3, head=13, tail=13, FIFO pre-filled with 4 beats, wready=1:
  - `wstrb` sequence is 0xFFFF_FFFF_FFFF_E000, 0xFFFF_FFFF_FFFF_FFFF, 0xFFFF_FFFF_FFFF_FFFF, 0x0000_0000_0000_3FFF;
  - `wlast` high on beat 4 only;
  - `done_o` one cycle later;
  - first `wvalid` two cycles after acceptance.
- alen=0, head=3, tail=7: one beat, wstrb=0x0000_0000_0000_00F8, wlast=1.
- wready low for 3 cycles on beat 2 of alen=2: beat 2 data, strb and last held stable; exactly 3 pops total; no FIFO pop while stalled with wvalid high.
- FIFO empty for 5 cycles after beat 1 of alen=1: wvalid drops after beat 1, beat 2 is sent after data arrives, `done_o` fires once.
- Two back-to-back descriptors (alen=1, then alen=0) with `req_valid_i` held: second accepted in the `done_o` cycle; 3 W beats total with correct wlast placement.
- rstn asserted mid-burst (after beat 1 of alen=3): all outputs reach reset values asynchronously; after release, a new alen=0 burst completes normally. With `DMA_WSTREAM_ERR_EN`, alen=0, head=9, tail=2 gives a zero strobe and sticky `err_o`=1.
